// File: rtl/cpu_defs.sv
// cpu_defs: shared widths, ALU codes, forward-select and operand-source encodings
package cpu_defs;
  localparam int XLEN = 32;
  localparam int REG_AW = 5;
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_LUI  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_SLTU = 4'b1010;
  typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_MEM = 2'b01, FWD_WB = 2'b10} fwd_sel_e;
  typedef enum logic {SRCA_RS1 = 1'b0, SRCA_PC = 1'b1} src_a_e;
  typedef enum logic {SRCB_RS2 = 1'b0, SRCB_IMM = 1'b1} src_b_e;
endpackage

// File: rtl/forward_unit.sv
// forward_unit: picks the bypass source for one EX-stage source register
module forward_unit #(
  parameter int REG_AW = cpu_defs::REG_AW
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic              reg_write_mem,
  input  logic [REG_AW-1:0] rd_addr_mem,
  input  logic              reg_write_wb,
  input  logic [REG_AW-1:0] rd_addr_wb,
  output cpu_defs::fwd_sel_e fwd_sel
);
  always_comb
    fwd_sel = (reg_write_mem && rd_addr_mem != '0 && rd_addr_mem == rs_addr) ? cpu_defs::FWD_MEM :
              (reg_write_wb && rd_addr_wb != '0 && rd_addr_wb == rs_addr) ? cpu_defs::FWD_WB :
              cpu_defs::FWD_RF;
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with EX operand forwarding and load-use detection
module id_ex_operand_stage #(
  parameter int XLEN = cpu_defs::XLEN,
  parameter int REG_AW = cpu_defs::REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        ALUCode_id,
  input  logic              ALUSrcA_id,
  input  logic              ALUSrcB_id,
  input  logic              RegWrite_id,
  input  logic              MemRead_id,
  input  logic              MemWrite_id,
  input  logic              MemtoReg_id,
  input  logic [REG_AW-1:0] rs1Addr_id,
  input  logic [REG_AW-1:0] rs2Addr_id,
  input  logic [REG_AW-1:0] rdAddr_id,
  input  logic [XLEN-1:0]   rs1Data_id,
  input  logic [XLEN-1:0]   rs2Data_id,
  input  logic [XLEN-1:0]   imm_id,
  input  logic [XLEN-1:0]   PC_id,
  input  logic              RegWrite_mem,
  input  logic [REG_AW-1:0] rdAddr_mem,
  input  logic [XLEN-1:0]   ALUResult_mem,
  input  logic              RegWrite_wb,
  input  logic [REG_AW-1:0] rdAddr_wb,
  input  logic [XLEN-1:0]   WriteData_wb,
  output logic [3:0]        ALUCode_ex,
  output logic [XLEN-1:0]   A_ex,
  output logic [XLEN-1:0]   B_ex,
  output logic [XLEN-1:0]   storeData_ex,
  output logic              RegWrite_ex,
  output logic              MemRead_ex,
  output logic              MemWrite_ex,
  output logic              MemtoReg_ex,
  output logic [REG_AW-1:0] rdAddr_ex,
  output logic [XLEN-1:0]   PC_ex,
  output logic              load_use
);
  cpu_defs::src_a_e   src_a;
  cpu_defs::src_b_e   src_b;
  cpu_defs::fwd_sel_e sel_a, sel_b;
  logic [REG_AW-1:0]  rs1_addr, rs2_addr;
  logic [XLEN-1:0]    rs1_data, rs2_data, imm, fwd_a, fwd_b;
  always_ff @(posedge clk)
    if (!rst_n || flush) begin
      ALUCode_ex  <= cpu_defs::ALU_ADD;
      src_a       <= cpu_defs::SRCA_RS1;
      src_b       <= cpu_defs::SRCB_RS2;
      RegWrite_ex <= 1'b0;
      MemRead_ex  <= 1'b0;
      MemWrite_ex <= 1'b0;
      MemtoReg_ex <= 1'b0;
      rs1_addr    <= '0;
      rs2_addr    <= '0;
      rdAddr_ex   <= '0;
      rs1_data    <= '0;
      rs2_data    <= '0;
      imm         <= '0;
      PC_ex       <= '0;
    end else if (!stall) begin
      ALUCode_ex  <= ALUCode_id;
      src_a       <= cpu_defs::src_a_e'(ALUSrcA_id);
      src_b       <= cpu_defs::src_b_e'(ALUSrcB_id);
      RegWrite_ex <= RegWrite_id;
      MemRead_ex  <= MemRead_id;
      MemWrite_ex <= MemWrite_id;
      MemtoReg_ex <= MemtoReg_id;
      rs1_addr    <= rs1Addr_id;
      rs2_addr    <= rs2Addr_id;
      rdAddr_ex   <= rdAddr_id;
      rs1_data    <= rs1Data_id;
      rs2_data    <= rs2Data_id;
      imm         <= imm_id;
      PC_ex       <= PC_id;
    end
  forward_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .rs_addr(rs1_addr), .reg_write_mem(RegWrite_mem), .rd_addr_mem(rdAddr_mem),
    .reg_write_wb(RegWrite_wb), .rd_addr_wb(rdAddr_wb), .fwd_sel(sel_a)
  );
  forward_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .rs_addr(rs2_addr), .reg_write_mem(RegWrite_mem), .rd_addr_mem(rdAddr_mem),
    .reg_write_wb(RegWrite_wb), .rd_addr_wb(rdAddr_wb), .fwd_sel(sel_b)
  );
  always_comb begin
    fwd_a = sel_a == cpu_defs::FWD_MEM ? ALUResult_mem : sel_a == cpu_defs::FWD_WB ? WriteData_wb : rs1_data;
    fwd_b = sel_b == cpu_defs::FWD_MEM ? ALUResult_mem : sel_b == cpu_defs::FWD_WB ? WriteData_wb : rs2_data;
    A_ex = src_a == cpu_defs::SRCA_PC ? PC_ex : fwd_a;
    B_ex = src_b == cpu_defs::SRCB_IMM ? imm : fwd_b;
    storeData_ex = fwd_b;
    load_use = MemRead_ex && rdAddr_ex != '0 && (rdAddr_ex == rs1Addr_id || rdAddr_ex == rs2Addr_id);
  end
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and randomized checks against a behavioural stage model
module tb_id_ex_operand_stage;
  typedef struct packed {
    logic [3:0]  alu;
    logic        sa, sb, rw, mr, mw, m2r;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
  } stage_t;
  logic clk = 1'b0, rst_n = 1'b0, stall = 1'b0, flush = 1'b0;
  stage_t id_in = '0, ex_m = '0;
  logic rw_mem = 1'b0, rw_wb = 1'b0;
  logic [4:0] rd_mem = '0, rd_wb = '0;
  logic [31:0] alu_mem = '0, wd_wb = '0;
  logic [3:0] alu_ex;
  logic [31:0] a_ex, b_ex, st_ex, pc_ex;
  logic rw_ex, mr_ex, mw_ex, m2r_ex, lu;
  logic [4:0] rd_ex;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .ALUCode_id(id_in.alu), .ALUSrcA_id(id_in.sa), .ALUSrcB_id(id_in.sb),
    .RegWrite_id(id_in.rw), .MemRead_id(id_in.mr), .MemWrite_id(id_in.mw), .MemtoReg_id(id_in.m2r),
    .rs1Addr_id(id_in.rs1), .rs2Addr_id(id_in.rs2), .rdAddr_id(id_in.rd),
    .rs1Data_id(id_in.d1), .rs2Data_id(id_in.d2), .imm_id(id_in.imm), .PC_id(id_in.pc),
    .RegWrite_mem(rw_mem), .rdAddr_mem(rd_mem), .ALUResult_mem(alu_mem),
    .RegWrite_wb(rw_wb), .rdAddr_wb(rd_wb), .WriteData_wb(wd_wb),
    .ALUCode_ex(alu_ex), .A_ex(a_ex), .B_ex(b_ex), .storeData_ex(st_ex),
    .RegWrite_ex(rw_ex), .MemRead_ex(mr_ex), .MemWrite_ex(mw_ex), .MemtoReg_ex(m2r_ex),
    .rdAddr_ex(rd_ex), .PC_ex(pc_ex), .load_use(lu)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (!rst_n || flush) ex_m = '0;
    else if (!stall) ex_m = id_in;
    #1;
  endtask
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] rf);
    if (a != 0 && rw_mem && rd_mem == a) return alu_mem;
    if (a != 0 && rw_wb && rd_wb == a) return wd_wb;
    return rf;
  endfunction
  task automatic check_all();
    check("A", a_ex, ex_m.sa ? ex_m.pc : fwd(ex_m.rs1, ex_m.d1));
    check("B", b_ex, ex_m.sb ? ex_m.imm : fwd(ex_m.rs2, ex_m.d2));
    check("store", st_ex, fwd(ex_m.rs2, ex_m.d2));
    check("alu", 32'(alu_ex), 32'(ex_m.alu));
    check("ctl", {28'd0, rw_ex, mr_ex, mw_ex, m2r_ex}, {28'd0, ex_m.rw, ex_m.mr, ex_m.mw, ex_m.m2r});
    check("rd", 32'(rd_ex), 32'(ex_m.rd));
    check("pc", pc_ex, ex_m.pc);
    check("load_use", 32'(lu), 32'(ex_m.mr && ex_m.rd != 0 && (ex_m.rd == id_in.rs1 || ex_m.rd == id_in.rs2)));
  endtask
  initial begin
    id_in = '{alu: 4'hF, sa: 1, sb: 1, rw: 1, mr: 1, mw: 1, m2r: 1, rs1: 5'd3, rs2: 5'd4, rd: 5'd9,
              d1: 32'h1234, d2: 32'h5678, imm: 32'h9abc, pc: 32'h400};
    tick();
    tick();
    check("rst_alu", 32'(alu_ex), 32'h0);
    check("rst_ctl", {28'd0, rw_ex, mr_ex, mw_ex, m2r_ex}, 32'h0);
    check("rst_rd", 32'(rd_ex), 32'h0);
    check("rst_pc", pc_ex, 32'h0);
    check("rst_A", a_ex, 32'h0);
    check("rst_B", b_ex, 32'h0);
    rst_n = 1'b1;
    id_in = '0;
    id_in.alu = 4'b0001;
    id_in.rd = 5'd5;
    id_in.rw = 1'b1;
    tick();
    check("load_alu", 32'(alu_ex), 32'h1);
    check("load_rd", 32'(rd_ex), 32'h5);
    stall = 1'b1;
    id_in.alu = 4'b0010;
    id_in.rd = 5'd9;
    tick();
    check("stall_alu", 32'(alu_ex), 32'h1);
    check("stall_rd", 32'(rd_ex), 32'h5);
    flush = 1'b1;
    tick();
    check("flush_stall_rw", 32'(rw_ex), 32'h0);
    check("flush_stall_alu", 32'(alu_ex), 32'h0);
    stall = 1'b0;
    flush = 1'b0;
    id_in = '0;
    id_in.rs1 = 5'd3;
    id_in.d1 = 32'h33;
    tick();
    rw_mem = 1; rd_mem = 5'd3; alu_mem = 32'h11;
    rw_wb = 1; rd_wb = 5'd3; wd_wb = 32'h22;
    #1 check("dfwd_mem", a_ex, 32'h11);
    rw_mem = 0;
    #1 check("dfwd_wb", a_ex, 32'h22);
    rw_wb = 0;
    #1 check("dfwd_rf", a_ex, 32'h33);
    id_in = '0;
    tick();
    rw_mem = 1; rd_mem = 5'd0; alu_mem = 32'hDEAD;
    rw_wb = 1; rd_wb = 5'd0; wd_wb = 32'hBEEF;
    #1 check("x0_B", b_ex, 32'h0);
    check("x0_store", st_ex, 32'h0);
    rw_wb = 0;
    id_in.sa = 1; id_in.pc = 32'h100; id_in.sb = 1; id_in.imm = 32'hFFFFF000;
    id_in.rs2 = 5'd4; id_in.d2 = 32'h99;
    tick();
    rd_mem = 5'd4; alu_mem = 32'h55;
    #1 check("src_A", a_ex, 32'h100);
    check("src_B", b_ex, 32'hFFFFF000);
    check("src_store", st_ex, 32'h55);
    rw_mem = 0;
    id_in = '0;
    id_in.mr = 1; id_in.rw = 1; id_in.rd = 5'd7;
    tick();
    id_in = '0;
    id_in.rs1 = 5'd1; id_in.rs2 = 5'd7;
    #1 check("lu_hit", 32'(lu), 32'h1);
    id_in.rs2 = 5'd0; id_in.rs1 = 5'd0; id_in.mr = 1; id_in.rd = 5'd0;
    tick();
    #1 check("lu_x0", 32'(lu), 32'h0);
    id_in = '0;
    id_in.rd = 5'd7; id_in.rw = 1;
    tick();
    id_in.rs2 = 5'd7;
    #1 check("lu_nomr", 32'(lu), 32'h0);
    id_in.mr = 1;
    tick();
    #1 check("lu_hit2", 32'(lu), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_mr", 32'(mr_ex), 32'h0);
    check("flush_rw", 32'(rw_ex), 32'h0);
    for (int i = 0; i < 10000; i++) begin
      id_in.alu = 4'($urandom_range(0, 10));
      {id_in.sa, id_in.sb, id_in.rw, id_in.mr, id_in.mw, id_in.m2r} = 6'($urandom);
      id_in.rs1 = 5'($urandom_range(0, 7));
      id_in.rs2 = 5'($urandom_range(0, 7));
      id_in.rd = 5'($urandom_range(0, 7));
      id_in.d1 = $urandom; id_in.d2 = $urandom; id_in.imm = $urandom; id_in.pc = $urandom;
      stall = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 9) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick();
      rw_mem = 1'($urandom); rd_mem = 5'($urandom_range(0, 7)); alu_mem = $urandom;
      rw_wb = 1'($urandom); rd_wb = 5'($urandom_range(0, 7)); wd_wb = $urandom;
      id_in.rs1 = 5'($urandom_range(0, 7));
      id_in.rs2 = 5'($urandom_range(0, 7));
      #1 check_all();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
